grad_accum_engine: RTL and testbench

Parametrised backward-pass engine for one sigmoid output layer. It accepts one training sample (output activations, targets, previous-layer activations) and computes each output delta, δj = (aj − tj)·aj·(1 − aj). It then accumulates learning-rate-scaled weight and bias gradients over a mini-batch in an internal accumulator bank, which the update stage reads back through a random-access read port. It sits between the forward block and the weight-update stage, replacing fixed-size per-element gradient registers with one time-multiplexed datapath.

---
 rtl/bp_pkg.sv | 46 ++++
 rtl/grad_accum_engine_if.sv | 29 ++
 rtl/fxp_mul.sv | 27 ++
 rtl/grad_accum_engine.sv | 201 ++++++++++++++++++++
 tb/tb_grad_accum_engine.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared backprop package: fixed-point constants, the engine state
// encoding and the narrowing helpers also used by the forward blocks.
// Optional feature macro: GRAD_SAT_EN (clamp instead of wrap on narrowing).
package bp_pkg;

   localparam int FRAC_DEF = 10;
   localparam int ONE      = 1 << FRAC_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELTA = 2'd1,
      GRAD  = 2'd2,
      DONE  = 2'd3
   } bp_state_e;

   // Keep the low w bits and sign-extend them back to 64 bits.
   function automatic logic signed [63:0] wrap_to(input logic signed [63:0] v,
                                                  input int w);
      logic signed [63:0] t;
      t = v <<< (64 - w);
      return t >>> (64 - w);
   endfunction

   // Clamp to the signed range of a w-bit value.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                 input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = 64'sd0 - (64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Narrowing used everywhere a wide result drops to a register width.
   function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                 input int w);
`ifdef GRAD_SAT_EN
      return sat_to(v, w);
`else
      return wrap_to(v, w);
`endif
   endfunction

endpackage

// File: rtl/grad_accum_engine_if.sv
// Sample/command and read-back bus of the gradient accumulation engine.
// master = the sequencing side (forward block / update stage), slave = engine.
interface grad_accum_engine_if #(
   parameter int DW    = 16,
   parameter int N_OUT = 4,
   parameter int N_IN  = 5,
   parameter int AW    = $clog2(N_OUT * (N_IN + 1))
);
   logic                  start;
   logic                  clear;
   logic [N_OUT*DW-1:0]   a_out;
   logic [N_OUT*DW-1:0]   target;
   logic [N_IN*DW-1:0]    a_in;
   logic                  busy;
   logic                  done;
   logic [15:0]           n_samples;
   logic [AW-1:0]         rd_addr;
   logic [DW-1:0]         rd_data;

   modport master (
      output start, clear, a_out, target, a_in, rd_addr,
      input  busy, done, n_samples, rd_data
   );

   modport slave (
      input  start, clear, a_out, target, a_in, rd_addr,
      output busy, done, n_samples, rd_data
   );
endinterface

// File: rtl/fxp_mul.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC,
// then narrow to OW bits (wrap, or clamp when GRAD_SAT_EN is defined).
module fxp_mul #(
   parameter int AW   = 16,
   parameter int BW   = 16,
   parameter int FRAC = 10,
   parameter int OW   = 16
) (
   input  logic signed [AW-1:0] a,
   input  logic signed [BW-1:0] b,
   output logic signed [OW-1:0] p
);
   import bp_pkg::*;

   logic signed [AW+BW-1:0] prod;
   logic signed [63:0]      ext;
   logic signed [63:0]      shifted;

   // Multiply at full width so nothing is lost before the shift.
   always_comb begin
      prod    = a * b;
      ext     = 64'(prod);
      shifted = ext >>> FRAC;
      p       = OW'(narrow(shifted, OW));
   end

endmodule

// File: rtl/grad_accum_engine.sv
// Backward-pass engine for one sigmoid output layer. A latched sample is
// walked through DELTA (one neuron per cycle) and GRAD (one weight/bias
// element per cycle); -LR-scaled gradients accumulate in a flat bank
// read back through a registered random-access port.
// Optional feature macro: GRAD_SAT_EN (saturating accumulate / narrowing).
module grad_accum_engine
   import bp_pkg::*;
#(
   parameter int DW    = 16,
   parameter int FRAC  = 10,
   parameter int N_OUT = 4,
   parameter int N_IN  = 5,
   parameter int ACC_W = 32,
   parameter int LR    = 102
) (
   input  logic                clk,
   input  logic                rst,
   grad_accum_engine_if.slave  bus
);

   localparam int N_K = N_OUT * (N_IN + 1);
   localparam int KW  = $clog2(N_K);
   localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int IW  = $clog2(N_IN + 1);
   localparam int ONE_I = 1 << FRAC;
   localparam logic signed [DW:0]   ONE_X  = ONE_I[DW:0];
   localparam logic signed [DW-1:0] ONE_D  = ONE_I[DW-1:0];
   localparam logic signed [63:0]   LR_NEG = 64'sd0 - 64'(LR);

   bp_state_e                  state_q, state_d;
   logic [JW-1:0]              j_q, j_d;
   logic [IW-1:0]              i_q, i_d;
   logic [KW-1:0]              k_q, k_d;
   logic [N_OUT*DW-1:0]        a_out_q, a_out_d;
   logic [N_OUT*DW-1:0]        target_q, target_d;
   logic [N_IN*DW-1:0]         a_in_q, a_in_d;
   logic signed [DW-1:0]       delta_q [N_OUT];
   logic signed [DW-1:0]       delta_d [N_OUT];
   logic signed [ACC_W-1:0]    acc_q [N_K];
   logic signed [ACC_W-1:0]    acc_d [N_K];
   logic [15:0]                n_samples_q, n_samples_d;
   logic                       done_q, done_d;
   logic [DW-1:0]              rd_data_q, rd_data_d;

   logic signed [DW-1:0]       aj, tj;
   logic signed [DW:0]         one_m_a, a_m_t;
   logic signed [DW-1:0]       dadz, delta_new;
   logic [IW-1:0]              isel;
   logic signed [DW-1:0]       xi;
   logic signed [2*DW-1:0]     dw;
   logic signed [63:0]         acc_sum;
   logic signed [ACC_W-1:0]    acc_new;
   logic signed [63:0]         rd_ext;

   // Operand selection for the delta path: neuron j of the latched sample.
   always_comb begin
      aj      = a_out_q[int'(j_q)*DW +: DW];
      tj      = target_q[int'(j_q)*DW +: DW];
      one_m_a = ONE_X - {aj[DW-1], aj};
      a_m_t   = {aj[DW-1], aj} - {tj[DW-1], tj};
   end

   fxp_mul #(.AW(DW+1), .BW(DW), .FRAC(FRAC), .OW(DW)) u_dadz (
      .a (one_m_a),
      .b (aj),
      .p (dadz)
   );

   fxp_mul #(.AW(DW+1), .BW(DW), .FRAC(FRAC), .OW(DW)) u_delta (
      .a (a_m_t),
      .b (dadz),
      .p (delta_new)
   );

   // Input column i; the extra column is the bias with a constant 1.0 input.
   always_comb begin
      isel = (int'(i_q) < N_IN) ? i_q : '0;
      xi   = (int'(i_q) < N_IN) ? a_in_q[int'(isel)*DW +: DW] : ONE_D;
   end

   fxp_mul #(.AW(DW), .BW(DW), .FRAC(FRAC), .OW(2*DW)) u_dw (
      .a (delta_q[j_q]),
      .b (xi),
      .p (dw)
   );

   // Accumulate -LR * dw into element k; the sum is formed wide, then narrowed.
   always_comb begin
      acc_sum = 64'(acc_q[k_q]) + LR_NEG * 64'(dw);
      acc_new = ACC_W'(narrow(acc_sum, ACC_W));
   end

   // Read-back port: scaled to Q.FRAC, out-of-range addresses read zero.
   always_comb begin
      rd_ext = '0;
      if (32'(bus.rd_addr) < N_K) rd_ext = 64'(acc_q[bus.rd_addr]) >>> FRAC;
      rd_data_d = DW'(narrow(rd_ext, DW));
   end

   // Sequencer: next state, counters, sample latch, delta and accumulator bank.
   always_comb begin
      state_d     = state_q;
      j_d         = j_q;
      i_d         = i_q;
      k_d         = k_q;
      a_out_d     = a_out_q;
      target_d    = target_q;
      a_in_d      = a_in_q;
      delta_d     = delta_q;
      acc_d       = acc_q;
      n_samples_d = n_samples_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // clear lands first so a simultaneous start accumulates onto zero
            if (bus.clear) begin
               for (int k = 0; k < N_K; k++) acc_d[k] = '0;
               n_samples_d = '0;
            end
            if (bus.start) begin
               a_out_d  = bus.a_out;
               target_d = bus.target;
               a_in_d   = bus.a_in;
               j_d      = '0;
               state_d  = DELTA;
            end
         end
         DELTA: begin
            delta_d[j_q] = delta_new;
            if (j_q == JW'(N_OUT - 1)) begin
               j_d     = '0;
               i_d     = '0;
               k_d     = '0;
               state_d = GRAD;
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         GRAD: begin
            acc_d[k_q] = acc_new;
            if (k_q == KW'(N_K - 1)) begin
               j_d     = '0;
               i_d     = '0;
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
               if (i_q == IW'(N_IN)) begin
                  i_d = '0;
                  j_d = j_q + JW'(1);
               end else begin
                  i_d = i_q + IW'(1);
               end
            end
         end
         DONE: begin
            done_d = 1'b1;
            if (n_samples_q != 16'hFFFF) n_samples_d = n_samples_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset wipes the sample, deltas and the whole bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         j_q         <= '0;
         i_q         <= '0;
         k_q         <= '0;
         a_out_q     <= '0;
         target_q    <= '0;
         a_in_q      <= '0;
         for (int j = 0; j < N_OUT; j++) delta_q[j] <= '0;
         for (int k = 0; k < N_K; k++) acc_q[k] <= '0;
         n_samples_q <= '0;
         done_q      <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         j_q         <= j_d;
         i_q         <= i_d;
         k_q         <= k_d;
         a_out_q     <= a_out_d;
         target_q    <= target_d;
         a_in_q      <= a_in_d;
         delta_q     <= delta_d;
         acc_q       <= acc_d;
         n_samples_q <= n_samples_d;
         done_q      <= done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.n_samples = n_samples_q;
   assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_grad_accum_engine.sv
// Directed bench for grad_accum_engine: a table of sample/clear steps with
// hand-computed read-back values, plus sequences for busy-time commands,
// combined clear+start, mid-sample reset and the overflow case.
module tb_grad_accum_engine;

   localparam int DW    = 16;
   localparam int FRAC  = 10;
   localparam int N_OUT = 4;
   localparam int N_IN  = 5;
   localparam int N_K   = N_OUT * (N_IN + 1);
   localparam int AW    = $clog2(N_K);
   localparam int LAT   = 1 + N_OUT + N_K;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   grad_accum_engine_if #(.DW(DW), .N_OUT(N_OUT), .N_IN(N_IN)) bus ();

   grad_accum_engine #(
      .DW(DW), .FRAC(FRAC), .N_OUT(N_OUT), .N_IN(N_IN), .ACC_W(32), .LR(102)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      string name;
      int    op;      // 0 = read only, 1 = sample, 2 = clear
      int    a, t, x;
      int    exp_w, exp_b, exp_n;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_bcast(input int a, input int t, input int x);
      for (int j = 0; j < N_OUT; j++) begin
         bus.a_out[j*DW +: DW]  = DW'(a);
         bus.target[j*DW +: DW] = DW'(t);
      end
      for (int i = 0; i < N_IN; i++) bus.a_in[i*DW +: DW] = DW'(x);
   endtask

   task automatic do_clear();
      @(negedge clk); bus.clear = 1'b1;
      @(negedge clk); bus.clear = 1'b0;
   endtask

   // Pulse start, then expect exactly one done after LAT cycles.
   task automatic run_sample(input string tag);
      int lat;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk({tag, " busy"}, int'(bus.busy), 1);
      lat = 0;
      while (!bus.done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, lat, LAT);
      @(negedge clk);
      chk({tag, " done pulse"}, int'(bus.done), 0);
      chk({tag, " busy after"}, int'(bus.busy), 0);
   endtask

   task automatic read_one(input string tag, input int k, input int exp);
      @(negedge clk); bus.rd_addr = AW'(k);
      @(negedge clk);
      chk($sformatf("%s rd[%0d]", tag, k), int'($signed(bus.rd_data)), exp);
   endtask

   task automatic read_all(input string tag, input int exp_w, input int exp_b);
      for (int k = 0; k < N_K; k++)
         read_one(tag, k, (k % (N_IN + 1) == N_IN) ? exp_b : exp_w);
   endtask

   vec_t vecs[7];

   initial begin
      int ndone;
      int exp_sat;

      // a=0.5 t=0 x=1.0: dadz 256, delta 128, acc -13056 -> -13
      // a=0.75 t=1.0 x=0.5: dadz 192, delta -48, acc w 2448 -> 2, b 4896 -> 4
      vecs[0] = '{"reset",    0,   0,    0,    0,   0,   0, 0};
      vecs[1] = '{"one",      1, 512,    0, 1024, -13, -13, 1};
      vecs[2] = '{"two",      1, 512,    0, 1024, -26, -26, 2};
      vecs[3] = '{"clear",    2,   0,    0,    0,   0,   0, 0};
      vecs[4] = '{"negdelta", 1, 768, 1024,  512,   2,   4, 1};
      vecs[5] = '{"zerodelta",1, 512,  512, 1024,   2,   4, 2};
      vecs[6] = '{"clear2",   2,   0,    0,    0,   0,   0, 0};

      bus.start = 1'b0; bus.clear = 1'b0; bus.rd_addr = '0;
      bus.a_out = '0; bus.target = '0; bus.a_in = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset n", int'(bus.n_samples), 0);
      chk("reset rd_data", int'($signed(bus.rd_data)), 0);

      foreach (vecs[v]) begin
         case (vecs[v].op)
            1: begin
               set_bcast(vecs[v].a, vecs[v].t, vecs[v].x);
               run_sample(vecs[v].name);
            end
            2: do_clear();
            default: ;
         endcase
         chk({vecs[v].name, " n"}, int'(bus.n_samples), vecs[v].exp_n);
         read_all(vecs[v].name, vecs[v].exp_w, vecs[v].exp_b);
      end

      // start and clear during GRAD are ignored; latched sample is used
      set_bcast(512, 0, 1024);
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (10) @(negedge clk);
      set_bcast(768, 1024, 512);
      bus.start = 1'b1; bus.clear = 1'b1;
      @(negedge clk); bus.start = 1'b0; bus.clear = 1'b0;
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("busy-cmd dones", ndone, 1);
      chk("busy-cmd n", int'(bus.n_samples), 1);
      read_all("busy-cmd", -13, -13);

      // clear + start together: the sample lands on a cleared bank
      set_bcast(512, 0, 1024);
      @(negedge clk); bus.start = 1'b1; bus.clear = 1'b1;
      @(negedge clk); bus.start = 1'b0; bus.clear = 1'b0;
      ndone = 0;
      while (!bus.done && ndone < 200) begin
         @(negedge clk);
         ndone++;
      end
      chk("clr+start latency", ndone, LAT);
      @(negedge clk);
      chk("clr+start n", int'(bus.n_samples), 1);
      read_all("clr+start", -13, -13);

      // reset mid-GRAD wipes everything, then a fresh sample works
      set_bcast(512, 0, 1024);
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", int'(bus.busy), 0);
      chk("midrst done", int'(bus.done), 0);
      chk("midrst n", int'(bus.n_samples), 0);
      chk("midrst rd_data", int'($signed(bus.rd_data)), 0);
      read_all("midrst", 0, 0);
      run_sample("post-rst");
      chk("post-rst n", int'(bus.n_samples), 1);
      read_all("post-rst", -13, -13);

      // overflow case: delta 8064, acc0 -25498368 then -50996736
      do_clear();
      bus.a_out = '0; bus.target = '0; bus.a_in = '0;
      bus.a_out[DW-1:0]  = DW'(512);
      bus.target[DW-1:0] = DW'(-31744);
      bus.a_in[DW-1:0]   = DW'(31744);
      run_sample("sat1");
      read_one("sat1", 0, -24901);
      read_one("sat1", 1, 0);
      read_one("sat1", N_IN, -804);
      read_one("sat1", N_IN + 1, 0);
      run_sample("sat2");
`ifdef GRAD_SAT_EN
      exp_sat = -32768;
`else
      exp_sat = 15734;
`endif
      read_one("sat2", 0, exp_sat);
      read_one("sat2", N_IN, -1607);
      chk("sat2 n", int'(bus.n_samples), 2);
      for (int k = N_K; k < (1 << AW); k++) read_one("oor", k, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
